// File: rtl/gshare_branch_predictor_pkg.sv
// Shared constants, FSM state type and counter init helper for the gshare branch predictor.
package bp_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    // Weak not-taken: the largest value whose MSB is still clear.
    function automatic int bp_init_val(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_if.sv
// Fetch-side lookup and EX-side resolve bundle between the pipeline and the predictor.
interface gshare_branch_predictor_if #(
    parameter int HIST_BITS = 6
);
    logic [31:0]          i_fetch_pc;
    logic                 i_fetch_is_branch;
    logic                 o_predict_taken;
    logic [HIST_BITS-1:0] o_fetch_ghr;
    logic                 o_ready;
    logic                 i_ex_valid;
    logic [31:0]          i_ex_pc;
    logic [HIST_BITS-1:0] i_ex_ghr;
    logic                 i_ex_taken;
    logic                 i_ex_mispredict;
    logic [31:0]          o_branch_count;
    logic [31:0]          o_mispredict_count;

    modport master (
        output i_fetch_pc, i_fetch_is_branch,
        output i_ex_valid, i_ex_pc, i_ex_ghr, i_ex_taken, i_ex_mispredict,
        input  o_predict_taken, o_fetch_ghr, o_ready,
        input  o_branch_count, o_mispredict_count
    );

    modport slave (
        input  i_fetch_pc, i_fetch_is_branch,
        input  i_ex_valid, i_ex_pc, i_ex_ghr, i_ex_taken, i_ex_mispredict,
        output o_predict_taken, o_fetch_ghr, o_ready,
        output o_branch_count, o_mispredict_count
    );
endinterface

// File: rtl/gshare_branch_predictor_sat_counter.sv
// Combinational up/down saturating counter next-state used for table updates.
module bp_sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                up,
    output logic [CTR_BITS-1:0] ctr_next
);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != CTR_MAX) ctr_next = ctr + 1'b1;
        end else begin
            if (ctr != '0) ctr_next = ctr - 1'b1;
        end
    end
endmodule

// File: rtl/gshare_branch_predictor.sv
// Bimodal/gshare direction predictor: counter table with post-reset sweep, speculative GHR
// with mispredict repair, and saturating branch/mispredict counters.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 6,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = BP_MODE_GSHARE
) (
    input  logic clk,
    input  logic rst,
    gshare_branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(bp_init_val(CTR_BITS));

    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist
        $error("gshare_branch_predictor: HIST_BITS must satisfy 0 < HIST_BITS <= INDEX_BITS");
    end
    if (CTR_BITS < 2) begin : g_bad_ctr
        $error("gshare_branch_predictor: CTR_BITS must be >= 2");
    end

    bp_state_t             state_reg, state_next;
    logic [INDEX_BITS-1:0] ptr_reg;
    logic [HIST_BITS-1:0]  ghr_reg, ghr_next, ghr_shift, ghr_repair;
    logic [31:0]           branch_count_reg, mispredict_count_reg;
    logic [CTR_BITS-1:0]   table_mem [DEPTH];

    logic                  ready, ex_upd, ex_fix, predict;
    logic [INDEX_BITS-1:0] fidx, eidx, fhist, ehist;
    logic [CTR_BITS-1:0]   fetch_ctr, ex_ctr, ex_ctr_next;
    logic                  table_we;
    logic [INDEX_BITS-1:0] table_waddr;
    logic [CTR_BITS-1:0]   table_wdata;
    logic                  unused_pc_bits;

    assign ready  = (state_reg == BP_RUN);
    assign ex_upd = ready & bp.i_ex_valid;
    assign ex_fix = ex_upd & bp.i_ex_mispredict;

    assign fhist = (MODE == BP_MODE_GSHARE) ? INDEX_BITS'(ghr_reg)     : '0;
    assign ehist = (MODE == BP_MODE_GSHARE) ? INDEX_BITS'(bp.i_ex_ghr) : '0;
    assign fidx  = bp.i_fetch_pc[INDEX_BITS+1:2] ^ fhist;
    assign eidx  = bp.i_ex_pc[INDEX_BITS+1:2] ^ ehist;

    assign unused_pc_bits = ^{bp.i_fetch_pc[31:INDEX_BITS+2], bp.i_fetch_pc[1:0],
                              bp.i_ex_pc[31:INDEX_BITS+2], bp.i_ex_pc[1:0]};

    // Asynchronous read: the prediction must be available in the fetch cycle.
    assign fetch_ctr = table_mem[fidx];
    assign ex_ctr    = table_mem[eidx];
    assign predict   = ready & fetch_ctr[CTR_BITS-1];

    bp_sat_counter #(.CTR_BITS(CTR_BITS)) u_sat (
        .ctr      (ex_ctr),
        .up       (bp.i_ex_taken),
        .ctr_next (ex_ctr_next)
    );

    if (HIST_BITS == 1) begin : g_hist1
        assign ghr_shift  = predict;
        assign ghr_repair = bp.i_ex_taken;
    end else begin : g_histn
        assign ghr_shift  = {ghr_reg[HIST_BITS-2:0], predict};
        assign ghr_repair = {bp.i_ex_ghr[HIST_BITS-2:0], bp.i_ex_taken};
    end

    // Repair wins: the fetch shifting in this cycle belongs to the flushed path.
    always_comb begin
        ghr_next = ghr_reg;
        if (ex_fix)
            ghr_next = ghr_repair;
        else if (ready && bp.i_fetch_is_branch)
            ghr_next = ghr_shift;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            BP_INIT: if (&ptr_reg) state_next = BP_RUN;
            BP_RUN:  state_next = BP_RUN;
            default: state_next = BP_INIT;
        endcase
    end

    always_comb begin
        table_we    = 1'b0;
        table_waddr = eidx;
        table_wdata = ex_ctr_next;
        if (!rst) begin
            if (state_reg == BP_INIT) begin
                table_we    = 1'b1;
                table_waddr = ptr_reg;
                table_wdata = INIT_VAL;
            end else if (ex_upd) begin
                table_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (table_we) table_mem[table_waddr] <= table_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= BP_INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == BP_INIT) ptr_reg <= ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_reg              <= '0;
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else begin
            ghr_reg <= ghr_next;
            if (ex_upd && branch_count_reg != 32'hFFFF_FFFF)
                branch_count_reg <= branch_count_reg + 32'd1;
            if (ex_fix && mispredict_count_reg != 32'hFFFF_FFFF)
                mispredict_count_reg <= mispredict_count_reg + 32'd1;
        end
    end

    assign bp.o_predict_taken    = predict;
    assign bp.o_fetch_ghr        = ghr_reg;
    assign bp.o_ready            = ready;
    assign bp.o_branch_count     = branch_count_reg;
    assign bp.o_mispredict_count = mispredict_count_reg;
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed scoreboard bench: a gshare and a bimodal instance driven side by side.
module tb_gshare_branch_predictor;
    import bp_pkg::*;

    logic clk;
    logic rst;

    gshare_branch_predictor_if #(.HIST_BITS(6)) gif ();
    gshare_branch_predictor_if #(.HIST_BITS(6)) bif ();

    gshare_branch_predictor #(.MODE(BP_MODE_GSHARE)) dut_g (.clk(clk), .rst(rst), .bp(gif));
    gshare_branch_predictor #(.MODE(BP_MODE_BIMODAL)) dut_b (.clk(clk), .rst(rst), .bp(bif));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_obs(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            $display("[%0t] %s observed=%h expected=%h", $time, e.tag, obs, e.exp);
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic clear_ex();
        gif.i_ex_valid = 0; gif.i_ex_mispredict = 0; gif.i_ex_taken = 0;
        gif.i_ex_pc = '0;   gif.i_ex_ghr = '0;
        bif.i_ex_valid = 0; bif.i_ex_mispredict = 0; bif.i_ex_taken = 0;
        bif.i_ex_pc = '0;   bif.i_ex_ghr = '0;
    endtask

    task automatic drv_idle();
        gif.i_fetch_pc = '0; gif.i_fetch_is_branch = 0;
        bif.i_fetch_pc = '0; bif.i_fetch_is_branch = 0;
        clear_ex();
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!gif.o_ready && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    // Fetch every index with the current GHR (0 here) and OR all predictions together.
    task automatic scan_all(output logic any_taken);
        any_taken = 1'b0;
        for (int i = 0; i < 64; i++) begin
            gif.i_fetch_pc = 32'(i) << 2;
            bif.i_fetch_pc = 32'(i) << 2;
            #1;
            any_taken = any_taken | gif.o_predict_taken | bif.o_predict_taken;
        end
    endtask

    logic       bim_taken [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
    logic       bim_mp    [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    logic       bim_pred  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int         cyc;
    logic       any_taken;

    initial begin
        rst = 1'b1;
        drv_idle();
        tick();
        tick();

        // Reset state
        push_exp("rst_ready", 0);          check_obs({31'b0, gif.o_ready});
        push_exp("rst_predict", 0);        check_obs({31'b0, gif.o_predict_taken});
        push_exp("rst_ghr", 0);            check_obs({26'b0, gif.o_fetch_ghr});
        push_exp("rst_branch_count", 0);   check_obs(gif.o_branch_count);
        push_exp("rst_mispredict_count", 0); check_obs(gif.o_mispredict_count);

        rst = 1'b0;
        push_exp("sweep_cycles", 64);
        wait_ready(cyc);
        check_obs(32'(cyc));
        push_exp("bimodal_ready", 1);      check_obs({31'b0, bif.o_ready});

        push_exp("init_all_not_taken", 0);
        scan_all(any_taken);
        check_obs({31'b0, any_taken});
        tick();

        // Bimodal PC 0x40: saturate up at 11, then down to 00 and back up
        for (int k = 0; k < 8; k++) begin
            bif.i_ex_valid = 1; bif.i_ex_pc = 32'h40; bif.i_ex_ghr = 6'h2A;
            bif.i_ex_taken = bim_taken[k]; bif.i_ex_mispredict = bim_mp[k];
            push_exp($sformatf("bim_step%0d", k), {31'b0, bim_pred[k]});
            tick();
            clear_ex();
            bif.i_fetch_pc = 32'h40;
            #1;
            check_obs({31'b0, bif.o_predict_taken});
        end
        push_exp("bim_branch_count", 8);     check_obs(bif.o_branch_count);
        push_exp("bim_mispredict_count", 4); check_obs(bif.o_mispredict_count);
        tick();

        // Gshare: repair GHR to 000011 (writes entry 0^1=1 up to 10)
        gif.i_ex_valid = 1; gif.i_ex_mispredict = 1; gif.i_ex_pc = 32'h0;
        gif.i_ex_ghr = 6'b000001; gif.i_ex_taken = 1;
        push_exp("gs_ghr_repair_to_03", 32'h03);
        tick();
        clear_ex();
        check_obs({26'b0, gif.o_fetch_ghr});
        gif.i_fetch_pc = 32'h40;
        #1;
        push_exp("gs_fidx13_before", 0);   check_obs({31'b0, gif.o_predict_taken});

        gif.i_ex_valid = 1; gif.i_ex_pc = 32'h40; gif.i_ex_ghr = 6'b000011; gif.i_ex_taken = 1;
        push_exp("gs_fidx13_after", 1);
        tick();
        clear_ex();
        check_obs({31'b0, gif.o_predict_taken});
        gif.i_fetch_pc = 32'h4C;
        #1;
        push_exp("gs_fidx10_untouched", 0); check_obs({31'b0, gif.o_predict_taken});
        gif.i_fetch_pc = 32'h08;
        #1;
        push_exp("gs_fidx01_updated", 1);  check_obs({31'b0, gif.o_predict_taken});
        tick();

        // Same-cycle update and lookup of entry 0x13 (10 -> 01)
        gif.i_fetch_pc = 32'h40;
        gif.i_ex_valid = 1; gif.i_ex_pc = 32'h40; gif.i_ex_ghr = 6'b000011; gif.i_ex_taken = 0;
        #1;
        push_exp("same_cycle_old_value", 1); check_obs({31'b0, gif.o_predict_taken});
        tick();
        clear_ex();
        #1;
        push_exp("same_cycle_new_value", 0); check_obs({31'b0, gif.o_predict_taken});
        tick();

        // Speculative shift: fidx 2^3=1 predicts taken, GHR 000011 -> 000111
        gif.i_fetch_pc = 32'h08; gif.i_fetch_is_branch = 1;
        #1;
        push_exp("spec_predict", 1);       check_obs({31'b0, gif.o_predict_taken});
        push_exp("spec_ghr_shift", 32'h07);
        tick();
        gif.i_fetch_is_branch = 0;
        check_obs({26'b0, gif.o_fetch_ghr});

        // Fetch branch (predict 0) with same-cycle mispredict repair
        gif.i_fetch_pc = 32'h40; gif.i_fetch_is_branch = 1;
        gif.i_ex_valid = 1; gif.i_ex_mispredict = 1; gif.i_ex_pc = 32'h0;
        gif.i_ex_ghr = 6'b101010; gif.i_ex_taken = 1;
        #1;
        push_exp("flush_fetch_predict", 0); check_obs({31'b0, gif.o_predict_taken});
        push_exp("repair_beats_shift", 32'h15);
        tick();
        gif.i_fetch_is_branch = 0;
        clear_ex();
        check_obs({26'b0, gif.o_fetch_ghr});

        // Mispredict without valid is ignored
        gif.i_ex_mispredict = 1; gif.i_ex_ghr = 6'h3F;
        push_exp("unqualified_mispredict_ghr", 32'h15);
        tick();
        clear_ex();
        check_obs({26'b0, gif.o_fetch_ghr});
        push_exp("gs_branch_count", 4);     check_obs(gif.o_branch_count);
        push_exp("gs_mispredict_count", 2); check_obs(gif.o_mispredict_count);

        // Reset mid-sweep with EX traffic during INIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        gif.i_ex_valid = 1; gif.i_ex_mispredict = 1; gif.i_ex_taken = 1;
        gif.i_ex_pc = 32'h40; gif.i_ex_ghr = '0;
        gif.i_fetch_is_branch = 1;
        repeat (30) tick();
        gif.i_fetch_pc = 32'hA8;
        #1;
        push_exp("init_cycle30_ready", 0);   check_obs({31'b0, gif.o_ready});
        push_exp("init_predict_gated", 0);   check_obs({31'b0, gif.o_predict_taken});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_exp("restart_sweep_cycles", 64);
        wait_ready(cyc);
        clear_ex();
        gif.i_fetch_is_branch = 0;
        check_obs(32'(cyc));
        push_exp("init_branch_count", 0);     check_obs(gif.o_branch_count);
        push_exp("init_mispredict_count", 0); check_obs(gif.o_mispredict_count);
        push_exp("init_ghr_frozen", 0);       check_obs({26'b0, gif.o_fetch_ghr});
        push_exp("resweep_all_not_taken", 0);
        scan_all(any_taken);
        check_obs({31'b0, any_taken});

        if (sb_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
